invaders_pixel_renderer: RTL and testbench

Parametrised, pipelined per-pixel renderer for the invaders playfield. It takes the VGA sync counters and object positions, and produces registered 1-bit R/G/B. Compared with the previous draw block it adds:
- a configurable alien grid and bullet count
- fixed colour priority instead of OR-ing layers
- a 2-stage output pipeline
- a frame-counted hit-flash on the most recently destroyed alien

It sits between the game-state logic and the VGA pin registers.

---
 rtl/invaders_pixel_renderer.sv | 172 +++++++++++++++++
 tb/tb_invaders_pixel_renderer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/invaders_pixel_renderer.sv
// Two-stage pipelined pixel renderer for the invaders playfield: aliens on R, player on G, bullets on B.
// Define HIT_FLASH_EN to add a frame-counted white flash over the most recently destroyed alien cell.
module invaders_pixel_renderer #(
  parameter int NUM_ROWS     = 5,
  parameter int NUM_COLS     = 10,
  parameter int ALIEN_W      = 30,
  parameter int ALIEN_H      = 20,
  parameter int ALIEN_SP_X   = 10,
  parameter int ALIEN_SP_Y   = 10,
  parameter int PLAYER_W     = 30,
  parameter int PLAYER_H     = 20,
  parameter int NUM_BULLETS  = 4,
  parameter int BULLET_W     = 10,
  parameter int BULLET_H     = 20,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_ROWS*NUM_COLS-1:0]  Aliens_Grid,
  input  logic [8:0]                    AliensRow,
  input  logic [9:0]                    AliensCol,
  input  logic [8:0]                    PlayerRow,
  input  logic [9:0]                    PlayerCol,
  input  logic [9*NUM_BULLETS-1:0]      BulletRow,
  input  logic [10*NUM_BULLETS-1:0]     BulletCol,
  input  logic [NUM_BULLETS-1:0]        BulletExists,
  input  logic [9:0]                    CounterX,
  input  logic [9:0]                    CounterY,
  input  logic                          inDisplayArea,
  input  logic                          FrameStart,
  output logic                          R,
  output logic                          G,
  output logic                          B
);

  localparam int          NUM_CELLS   = NUM_ROWS * NUM_COLS;
  localparam int          IDX_W       = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [31:0] PITCH_X     = 32'(ALIEN_W + ALIEN_SP_X);
  localparam logic [31:0] PITCH_Y     = 32'(ALIEN_H + ALIEN_SP_Y);
  localparam logic [31:0] GRID_SPAN_X = 32'(NUM_COLS) * PITCH_X;
  localparam logic [31:0] GRID_SPAN_Y = 32'(NUM_ROWS) * PITCH_Y;
  localparam logic [31:0] ALIEN_W_L   = 32'(ALIEN_W);
  localparam logic [31:0] ALIEN_H_L   = 32'(ALIEN_H);
  localparam logic [31:0] NUM_COLS_L  = 32'(NUM_COLS);

  // All box bounds are 11 bits wide so a box hanging past X=1023 does not wrap to the left edge.
  logic [10:0]      pixX, pixY;
  logic [31:0]      dx, dy, colIdx, rowIdx;
  logic             cellInBox, alienHit, playerHit, bulletHit;
  logic [IDX_W-1:0] cellIdx;
  logic [10:0]      playerRight, playerBottom;
  logic [10:0]      bulletLeft, bulletTop;

  assign pixX = {1'b0, CounterX};
  assign pixY = {1'b0, CounterY};

  // Offsets into the alien grid are only meaningful when the pixel is right of / below the origin.
  assign dx     = 32'(pixX) - 32'({1'b0, AliensCol});
  assign dy     = 32'(pixY) - 32'({2'b00, AliensRow});
  assign colIdx = dx / PITCH_X;
  assign rowIdx = dy / PITCH_Y;

  assign cellInBox = (pixX >= {1'b0, AliensCol}) && (pixY >= {2'b00, AliensRow}) &&
                     (dx < GRID_SPAN_X) && (dy < GRID_SPAN_Y) &&
                     ((dx % PITCH_X) < ALIEN_W_L) && ((dy % PITCH_Y) < ALIEN_H_L);
  assign cellIdx   = IDX_W'(rowIdx * NUM_COLS_L + colIdx);
  assign alienHit  = cellInBox && Aliens_Grid[cellIdx];

  assign playerRight  = {1'b0, PlayerCol} + 11'(PLAYER_W);
  assign playerBottom = {2'b00, PlayerRow} + 11'(PLAYER_H);
  assign playerHit    = (pixX >= {1'b0, PlayerCol}) && (pixX < playerRight) &&
                        (pixY >= {2'b00, PlayerRow}) && (pixY < playerBottom);

  always_comb begin
    bulletHit  = 1'b0;
    bulletLeft = '0;
    bulletTop  = '0;
    for (int k = 0; k < NUM_BULLETS; k++) begin
      bulletLeft = {1'b0, BulletCol[10*k +: 10]};
      bulletTop  = {2'b00, BulletRow[9*k +: 9]};
      if (BulletExists[k] &&
          (pixX >= bulletLeft) && (pixX < bulletLeft + 11'(BULLET_W)) &&
          (pixY >= bulletTop) && (pixY < bulletTop + 11'(BULLET_H)))
        bulletHit = 1'b1;
    end
  end

  // ---- stage 1 boundary: registered hit flags ----
  logic vld_p1, alienHit_p1, playerHit_p1, bulletHit_p1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1       <= 1'b0;
      alienHit_p1  <= 1'b0;
      playerHit_p1 <= 1'b0;
      bulletHit_p1 <= 1'b0;
    end else begin
      vld_p1       <= inDisplayArea;
      alienHit_p1  <= alienHit;
      playerHit_p1 <= playerHit;
      bulletHit_p1 <= bulletHit;
    end
  end

  logic flashPix;

`ifdef HIT_FLASH_EN
  logic                 cellInBox_p1;
  logic [IDX_W-1:0]     cellIdx_p1;
  logic [NUM_CELLS-1:0] PrevGrid, fell;
  logic [7:0]           FlashCount;
  logic [IDX_W-1:0]     FlashIdx, fellIdx;

  always_ff @(posedge Clk) begin
    if (Reset) cellInBox_p1 <= 1'b0;
    else       cellInBox_p1 <= cellInBox;
  end

  always_ff @(posedge Clk) begin
    cellIdx_p1 <= cellIdx;
  end

  // Only falling grid bits count as kills; a new wave refilling the grid starts no flash.
  assign fell = PrevGrid & ~Aliens_Grid;

  always_comb begin
    fellIdx = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--)
      if (fell[i]) fellIdx = IDX_W'(i);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      PrevGrid   <= Aliens_Grid;
      FlashCount <= 8'd0;
      FlashIdx   <= '0;
    end else if (FrameStart) begin
      PrevGrid <= Aliens_Grid;
      if (|fell) begin
        FlashIdx   <= fellIdx;
        FlashCount <= 8'(FLASH_FRAMES);
      end else if (FlashCount != 8'd0) begin
        FlashCount <= FlashCount - 8'd1;
      end
    end
  end

  assign flashPix = (FlashCount != 8'd0) && cellInBox_p1 && (cellIdx_p1 == FlashIdx);
`else
  logic unusedFrameStart;
  assign unusedFrameStart = FrameStart;
  assign flashPix         = 1'b0;
`endif

  logic [2:0] rgbNext;

  always_comb begin
    rgbNext = 3'b000;
    if (!vld_p1)           rgbNext = 3'b000;
    else if (flashPix)     rgbNext = 3'b111;
    else if (bulletHit_p1) rgbNext = 3'b001;
    else if (playerHit_p1) rgbNext = 3'b010;
    else if (alienHit_p1)  rgbNext = 3'b100;
  end

  // ---- stage 2 boundary: registered colour outputs ----
  always_ff @(posedge Clk) begin
    if (Reset) {R, G, B} <= 3'b000;
    else       {R, G, B} <= rgbNext;
  end

endmodule

// File: tb/tb_invaders_pixel_renderer.sv
// Bench for invaders_pixel_renderer: geometric reference model checked every cycle, plus pinned
// literal expectations for the alien grid, priority, 11-bit bounds and hit-flash behaviour.
`timescale 1ns/1ps
module tb_invaders_pixel_renderer;
  localparam int NUM_ROWS = 5, NUM_COLS = 10, ALIEN_W = 30, ALIEN_H = 20;
  localparam int ALIEN_SP_X = 10, ALIEN_SP_Y = 10, PLAYER_W = 30, PLAYER_H = 20;
  localparam int NUM_BULLETS = 4, BULLET_W = 10, BULLET_H = 20, FLASH_FRAMES = 8;
  localparam int NCELLS = NUM_ROWS * NUM_COLS;
`ifdef HIT_FLASH_EN
  localparam bit FLASH_ON = 1'b1;
`else
  localparam bit FLASH_ON = 1'b0;
`endif
  localparam logic [2:0] FL = FLASH_ON ? 3'b111 : 3'b000;

  logic                     Clk = 1'b0;
  logic                     Reset = 1'b1;
  logic [NCELLS-1:0]        Aliens_Grid = '1;
  logic [8:0]               AliensRow = 9'd50;
  logic [9:0]               AliensCol = 10'd100;
  logic [8:0]               PlayerRow = 9'd400;
  logic [9:0]               PlayerCol = 10'd600;
  logic [9*NUM_BULLETS-1:0] BulletRow = '0;
  logic [10*NUM_BULLETS-1:0] BulletCol = '0;
  logic [NUM_BULLETS-1:0]   BulletExists = '0;
  logic [9:0]               CounterX = '0;
  logic [9:0]               CounterY = '0;
  logic                     inDisplayArea = 1'b0;
  logic                     FrameStart = 1'b0;
  logic                     R, G, B;

  invaders_pixel_renderer #(
    .NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H),
    .ALIEN_SP_X(ALIEN_SP_X), .ALIEN_SP_Y(ALIEN_SP_Y), .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H),
    .NUM_BULLETS(NUM_BULLETS), .BULLET_W(BULLET_W), .BULLET_H(BULLET_H), .FLASH_FRAMES(FLASH_FRAMES)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Aliens_Grid(Aliens_Grid),
    .AliensRow(AliensRow), .AliensCol(AliensCol), .PlayerRow(PlayerRow), .PlayerCol(PlayerCol),
    .BulletRow(BulletRow), .BulletCol(BulletCol), .BulletExists(BulletExists),
    .CounterX(CounterX), .CounterY(CounterY), .inDisplayArea(inDisplayArea),
    .FrameStart(FrameStart), .R(R), .G(G), .B(B)
  );

  initial forever #5 Clk = ~Clk;

  typedef struct {
    int                        cx, cy;
    bit                        disp;
    int                        aRow, aCol, pRow, pCol;
    logic [9*NUM_BULLETS-1:0]  bRow;
    logic [10*NUM_BULLETS-1:0] bCol;
    logic [NUM_BULLETS-1:0]    bEx;
    logic [NCELLS-1:0]         grid;
  } snap_t;

  function automatic snap_t capture();
    snap_t s;
    s.cx = int'(CounterX); s.cy = int'(CounterY); s.disp = inDisplayArea;
    s.aRow = int'(AliensRow); s.aCol = int'(AliensCol);
    s.pRow = int'(PlayerRow); s.pCol = int'(PlayerCol);
    s.bRow = BulletRow; s.bCol = BulletCol; s.bEx = BulletExists; s.grid = Aliens_Grid;
    return s;
  endfunction

  // Colour of one pixel from plain rectangle geometry, with unbounded integer arithmetic.
  function automatic logic [2:0] evalPixel(input snap_t s, input int fc, input int fi);
    bit alien = 0, inCell = 0, player, bullet = 0;
    int idx = -1;
    int x0, y0, bx, by;
    if (!s.disp) return 3'b000;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLS; c++) begin
        x0 = s.aCol + c * (ALIEN_W + ALIEN_SP_X);
        y0 = s.aRow + r * (ALIEN_H + ALIEN_SP_Y);
        if (s.cx >= x0 && s.cx < x0 + ALIEN_W && s.cy >= y0 && s.cy < y0 + ALIEN_H) begin
          inCell = 1; idx = r * NUM_COLS + c; alien = s.grid[idx];
        end
      end
    player = (s.cx >= s.pCol && s.cx < s.pCol + PLAYER_W && s.cy >= s.pRow && s.cy < s.pRow + PLAYER_H);
    for (int k = 0; k < NUM_BULLETS; k++) begin
      bx = int'(s.bCol[10*k +: 10]);
      by = int'(s.bRow[9*k +: 9]);
      if (s.bEx[k] && s.cx >= bx && s.cx < bx + BULLET_W && s.cy >= by && s.cy < by + BULLET_H) bullet = 1;
    end
    if (FLASH_ON && fc != 0 && inCell && idx == fi) return 3'b111;
    if (bullet) return 3'b001;
    if (player) return 3'b010;
    if (alien) return 3'b100;
    return 3'b000;
  endfunction

  snap_t             s1;
  bit                s1Live = 0, modelLive = 0;
  logic [2:0]        expOut = 3'b000;
  int                fCount = 0, fIdx = 0, cyc = 0;
  logic [NCELLS-1:0] mPrev = '0, mFell;
  int                vectors = 0, miscompares = 0;
  int                pinCyc[$];
  logic [2:0]        pinExp[$];
  string             pinName[$];

  // Model: pixel registered one edge, coloured on the next with the flash state of that moment.
  initial forever begin
    @(posedge Clk);
    cyc++;
    if (Reset) begin
      modelLive = 1; expOut = 3'b000; fCount = 0; fIdx = 0; mPrev = Aliens_Grid;
    end else if (modelLive) begin
      expOut = s1Live ? evalPixel(s1, fCount, fIdx) : 3'b000;
      if (FrameStart) begin
        mFell = mPrev & ~Aliens_Grid;
        mPrev = Aliens_Grid;
        if (mFell != '0) begin
          for (int i = NCELLS - 1; i >= 0; i--) if (mFell[i]) fIdx = i;
          fCount = FLASH_FRAMES;
        end else if (fCount > 0) begin
          fCount--;
        end
      end
    end
    s1 = capture();
    s1Live = !Reset;
  end

  initial forever begin
    @(negedge Clk);
    if (modelLive) begin
      vectors++;
      if ({R, G, B} !== expOut) begin
        miscompares++;
        $display("FAIL model cyc=%0d RGB got %b expected %b", cyc, {R, G, B}, expOut);
      end
      while (pinCyc.size() > 0 && pinCyc[0] <= cyc) begin
        vectors++;
        if (pinCyc[0] != cyc || {R, G, B} !== pinExp[0]) begin
          miscompares++;
          $display("FAIL %s cyc=%0d RGB got %b expected %b", pinName[0], cyc, {R, G, B}, pinExp[0]);
        end
        void'(pinCyc.pop_front()); void'(pinExp.pop_front()); void'(pinName.pop_front());
      end
    end
  end

  task automatic tick(); @(negedge Clk); endtask

  task automatic pix(input int x, input int y, input bit d);
    CounterX = 10'(x); CounterY = 10'(y); inDisplayArea = d;
  endtask

  task automatic pinAt(input string name, input int ofs, input logic [2:0] e);
    pinCyc.push_back(cyc + ofs); pinExp.push_back(e); pinName.push_back(name);
  endtask

  task automatic probe(input string name, input int x, input int y, input logic [2:0] e);
    pix(x, y, 1); pinAt(name, 2, e); tick();
  endtask

  task automatic frame(input string tag, input int ax, input int ay, input logic [2:0] ea,
                       input int bx, input int by, input logic [2:0] eb);
    pix(0, 0, 0); FrameStart = 1'b1; tick(); FrameStart = 1'b0;
    probe({tag, "_a"}, ax, ay, ea);
    probe({tag, "_b"}, bx, by, eb);
    pix(0, 0, 0); repeat (3) tick();
  endtask

  initial begin
    int x, y, k;
    repeat (3) tick();
    Reset = 1'b0;
    pix(100, 50, 1); pinAt("rst_latency", 1, 3'b000); pinAt("alien_origin", 2, 3'b100); tick();
    probe("alien_right_edge", 129, 50, 3'b100);
    probe("alien_gap", 130, 50, 3'b000);
    probe("past_col9", 499, 50, 3'b000);
    probe("past_row4", 100, 200, 3'b000);
    for (int f = 1; f <= 3; f++) frame($sformatf("steady%0d", f), 185, 85, 3'b100, 100, 50, 3'b100);

    PlayerCol = 10'd100; PlayerRow = 9'd50;
    BulletCol[29:20] = 10'd100; BulletRow[26:18] = 9'd50; BulletExists = 4'b0100;
    probe("bullet_over_all", 100, 50, 3'b001);
    BulletExists = 4'b0000;
    probe("player_over_alien", 100, 50, 3'b010);
    PlayerCol = 10'd600; PlayerRow = 9'd400;
    BulletCol[9:0] = 10'd1020; BulletRow[8:0] = 9'd300; BulletExists = 4'b0001;
    probe("bullet_no_wrap", 1023, 305, 3'b001);
    pix(1023, 305, 0); pinAt("blank_area", 2, 3'b000); tick();
    probe("left_of_bullet", 1019, 305, 3'b000);
    BulletExists = 4'b0000;

    Aliens_Grid[12] = 1'b0;
    for (int f = 1; f <= 9; f++)
      frame($sformatf("flashA%0d", f), 185, 85, (f <= 8) ? FL : 3'b000, 100, 50, 3'b100);
    Aliens_Grid = '1;
    frame("refill", 185, 85, 3'b100, 100, 50, 3'b100);
    Aliens_Grid[12] = 1'b0;
    for (int f = 1; f <= 4; f++)
      frame($sformatf("flashB%0d", f), 185, 85, FL, 225, 55, 3'b100);
    Aliens_Grid[3] = 1'b0;
    for (int f = 5; f <= 13; f++)
      frame($sformatf("flashC%0d", f), 185, 85, 3'b000, 225, 55, (f <= 12) ? FL : 3'b000);

    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) begin
        AliensCol = 10'($urandom_range(0, 1023)); AliensRow = 9'($urandom_range(0, 511));
        PlayerCol = 10'($urandom_range(0, 1023)); PlayerRow = 9'($urandom_range(0, 511));
        for (int j = 0; j < NUM_BULLETS; j++) begin
          BulletCol[10*j +: 10] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom);
          BulletRow[9*j +: 9] = 9'($urandom);
        end
        BulletExists = 4'($urandom);
      end
      if ($urandom_range(0, 99) < 3) Aliens_Grid[$urandom_range(0, NCELLS - 1)] = 1'b0;
      if ($urandom_range(0, 199) == 0) Aliens_Grid = NCELLS'({$urandom, $urandom});
      FrameStart = ($urandom_range(0, 19) == 0);
      Reset = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 3))
        0: begin x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023)); end
        1: begin x = int'(AliensCol) + int'($urandom_range(0, 410)); y = int'(AliensRow) + int'($urandom_range(0, 160)); end
        2: begin x = int'(PlayerCol) + int'($urandom_range(0, 40)) - 5; y = int'(PlayerRow) + int'($urandom_range(0, 30)) - 5; end
        default: begin
          k = int'($urandom_range(0, NUM_BULLETS - 1));
          x = int'(BulletCol[10*k +: 10]) + int'($urandom_range(0, 14)) - 2;
          y = int'(BulletRow[9*k +: 9]) + int'($urandom_range(0, 24)) - 2;
        end
      endcase
      pix(x, y, $urandom_range(0, 9) != 0);
      tick();
    end
    Reset = 1'b0; FrameStart = 1'b0; pix(0, 0, 0);
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
